pipelined_add_n_bit: RTL

PIPELINED_ADD_N_BIT -- requirements
Module: pipelined_add_n_bit

---
 rtl/pipelined_add_n_bit_pkg.sv | 16 +
 rtl/pipelined_add_n_bit_add_slice.sv | 29 ++
 rtl/pipelined_add_n_bit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipelined_add_n_bit_pkg.sv
// Shared defaults for the pipelined adder: operand width, stage count and
// the derived per-stage slice width.
// Imported by the top level and the slice adder.
package pipelined_add_n_bit_pkg;

  localparam int DEFAULT_N      = 8;
  localparam int DEFAULT_STAGES = 2;

  // Width of the operand slice handled by each pipeline stage.
  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  localparam int DEFAULT_W = slice_width(DEFAULT_N, DEFAULT_STAGES);

endpackage

// File: rtl/pipelined_add_n_bit_add_slice.sv
// Purpose: combinational W-bit adder slice with carry-in.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline register decides when to capture.
module add_slice
  import pipelined_add_n_bit_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] full;

  // One wide add; the extra bit is the slice carry-out.
  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  assign sum  = full[W-1:0];
  assign cout = full[W];

  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  // Using it avoids a second adder and also works when W = 1.
  assign c_msb = full[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/pipelined_add_n_bit.sv
// Purpose: N-bit add/subtract split into STAGES ripple slices with skew/deskew registers.
// Latency: exactly STAGES enabled cycles from in_valid to out_valid.
// Backpressure: en low freezes every register, including the valid bits.
module pipelined_add_n_bit
  import pipelined_add_n_bit_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         out_valid
);

  localparam int W = slice_width(N, STAGES);

  // Subtraction is a + ~b + 1: invert B up front, force the initial carry to 1.
  logic [N-1:0] b_eff;
  assign b_eff = b ^ {N{sub}};

  for (genvar k = 0; k < STAGES; k++) begin : stage
    localparam int LO = k * W;
    localparam int HI = LO + W;

    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [W-1:0]  ss;
    logic          cin_k;
    logic          cout_k;
    logic          cmsb_k;
    logic          vld_d;
    logic [HI-1:0] res_d;

    // Result bits [HI-1:0] completed so far, plus carry and valid for the next stage.
    logic [HI-1:0] res_q;
    logic          carry_q;
    logic          vld_q;

    if (k == 0) begin : g_src
      assign sa    = a[W-1:0];
      assign sb    = b_eff[W-1:0];
      assign cin_k = sub | c_in;
      assign vld_d = in_valid;
      assign res_d = ss;
    end else begin : g_src
      assign sa    = stage[k-1].g_skew.a_q[HI-1:LO];
      assign sb    = stage[k-1].g_skew.b_q[HI-1:LO];
      assign cin_k = stage[k-1].carry_q;
      assign vld_d = stage[k-1].vld_q;
      assign res_d = {ss, stage[k-1].res_q};
    end

    add_slice #(.W(W)) u_slice (
      .a    (sa),
      .b    (sb),
      .cin  (cin_k),
      .sum  (ss),
      .cout (cout_k),
      .c_msb(cmsb_k)
    );

    // Deskew: append this slice to the finished lower slices, and pass the carry and valid along.
    always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
        res_q   <= '0;
        carry_q <= 1'b0;
        vld_q   <= 1'b0;
      end else if (en) begin
        res_q   <= res_d;
        carry_q <= cout_k;
        vld_q   <= vld_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [N-1:HI] a_d;
      logic [N-1:HI] b_d;
      logic [N-1:HI] a_q;
      logic [N-1:HI] b_q;

      if (k == 0) begin : g_fwd
        assign a_d = a[N-1:HI];
        assign b_d = b_eff[N-1:HI];
      end else begin : g_fwd
        assign a_d = stage[k-1].g_skew.a_q[N-1:HI];
        assign b_d = stage[k-1].g_skew.b_q[N-1:HI];
      end

      // Skew: carry the unconsumed operand slices along with the carry.
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q;

      // Signed overflow: carry into the top bit differs from the carry out of it.
      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= cout_k ^ cmsb_k;
        end
      end
    end
  end

  assign sum       = stage[STAGES-1].res_q;
  assign c_out     = stage[STAGES-1].carry_q;
  assign overflow  = stage[STAGES-1].g_ovf.ovf_q;
  assign out_valid = stage[STAGES-1].vld_q;

endmodule
